// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Bundles the instruction-fetch port and the byte-stream image-load port of
// imem_loader.
//   ce, addr, inst                  : core fetch port (addr is a byte address)
//   ld_start, ld_valid, ld_byte,
//   ld_end, ld_ready                : image load stream
// master: core + image source side.  slave: imem_loader.
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              ce;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       inst;
  logic              ld_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [7:0]        ld_byte;
  logic              ld_end;

  modport master (
    output ce, addr, ld_start, ld_valid, ld_byte, ld_end,
    input  inst, ld_ready
  );

  modport slave (
    input  ce, addr, ld_start, ld_valid, ld_byte, ld_end,
    output inst, ld_ready
  );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Instruction RAM with a combinational fetch port and a runtime byte-stream
// loader. While an image is being loaded the core is held in reset.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        imem_loader_if.slave (fetch port + load stream)
//   core_hold  1 = core held in reset (registered)
//   ld_words   words written by the current/last load (saturates at DEPTH)
//   ld_err     sticky overflow flag, cleared by ld_start
//   ld_cksum   wrap-around sum of written words; only built when the macro
//              IMEM_CKSUM_EN is defined, otherwise tied to 0
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DEPTH    = 1024,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  imem_loader_if.slave      bus,
  output logic              core_hold,
  output logic [ADDR_W-2:0] ld_words,
  output logic              ld_err,
  output logic [31:0]       ld_cksum
);

  localparam int unsigned WPW = ADDR_W - 1;
  localparam int unsigned IW  = ADDR_W - 2;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  logic [31:0]    mem [DEPTH];

  state_t         state, state_n;
  logic [WPW-1:0] wptr, wptr_n;
  logic [1:0]     bidx, bidx_n;
  logic [23:0]    word_buf, word_buf_n;
  logic           err_n;
  logic           ready_q, ready_n;
  logic           hold_n;
  logic           accept;
  logic           full;
  logic           commit;
  logic           we;
  logic [31:0]    commit_data;
  logic [31:0]    pad_word;

  // Fetch: word index wraps modulo DEPTH; byte offset is irrelevant.
  logic [IW-1:0]  word_addr;
  logic [AW-1:0]  rd_idx;
  logic           unused_addr_bits;

  assign word_addr        = bus.addr[ADDR_W-1:2];
  assign unused_addr_bits = &{1'b0, bus.addr[1:0]};
  assign rd_idx           = AW'(32'(word_addr) % DEPTH);
  assign bus.inst         = bus.ce ? mem[rd_idx] : 32'h0;

  assign bus.ld_ready = ready_q;
  assign ld_words     = wptr;
  assign accept       = bus.ld_valid && ready_q;
  assign full         = (wptr == WPW'(DEPTH));

  // Final partial word: bytes at and above bidx take the pad value.
  always_comb begin
    pad_word = {4{PAD_BYTE}};
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < bidx) pad_word[8*i +: 8] = word_buf[8*i +: 8];
    end
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_n     = state;
    wptr_n      = wptr;
    bidx_n      = bidx;
    word_buf_n  = word_buf;
    err_n       = ld_err;
    commit      = 1'b0;
    commit_data = 32'h0;
    we          = 1'b0;

    if (bus.ld_start) begin
      // Restart from any state; a byte offered this cycle is dropped.
      state_n    = LOAD;
      wptr_n     = '0;
      bidx_n     = 2'd0;
      word_buf_n = 24'h0;
      err_n      = 1'b0;
    end else begin
      unique case (state)
        IDLE: state_n = IDLE;
        LOAD: begin
          if (accept) begin
            unique case (bidx)
              2'd0: word_buf_n[7:0]   = bus.ld_byte;
              2'd1: word_buf_n[15:8]  = bus.ld_byte;
              2'd2: word_buf_n[23:16] = bus.ld_byte;
              default: begin
                commit      = 1'b1;
                commit_data = {bus.ld_byte, word_buf};
              end
            endcase
            bidx_n = bidx + 2'd1;
          end
          // ld_end sees the byte index after this cycle's byte.
          if (bus.ld_end) state_n = (bidx_n != 2'd0) ? FLUSH : IDLE;
        end
        FLUSH: begin
          commit      = 1'b1;
          commit_data = pad_word;
          bidx_n      = 2'd0;
          state_n     = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    // A completed word past the end of RAM is dropped and flags overflow.
    if (commit) begin
      if (!full) begin
        we     = 1'b1;
        wptr_n = wptr + WPW'(1);
      end else begin
        err_n  = 1'b1;
      end
    end

    ready_n = (state_n == LOAD);
    // Hold spans the load plus the first IDLE cycle after it.
    hold_n  = (state_n != IDLE) || (state != IDLE);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wptr      <= '0;
      bidx      <= 2'd0;
      word_buf  <= 24'h0;
      ld_err    <= 1'b0;
      ready_q   <= 1'b0;
      core_hold <= 1'b1;
    end else begin
      state     <= state_n;
      wptr      <= wptr_n;
      bidx      <= bidx_n;
      word_buf  <= word_buf_n;
      ld_err    <= err_n;
      ready_q   <= ready_n;
      core_hold <= hold_n;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[AW'(wptr)] <= commit_data;
  end

`ifdef IMEM_CKSUM_EN
  logic [31:0] cksum;

  // Sum of words actually written in the current load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cksum <= 32'h0;
    else if (bus.ld_start) cksum <= 32'h0;
    else if (we)           cksum <= cksum + commit_data;
  end

  assign ld_cksum = cksum;
`else
  assign ld_cksum = 32'h0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader (DEPTH = 4 so overflow is reachable).
// Expected RAM words are queued as each image is driven and popped when the
// fetch port is read back. Checksum expectations follow IMEM_CKSUM_EN.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              core_hold;
  logic [ADDR_W-2:0] ld_words;
  logic              ld_err;
  logic [31:0]       ld_cksum;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .PAD_BYTE (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .core_hold (core_hold),
    .ld_words  (ld_words),
    .ld_err    (ld_err),
    .ld_cksum  (ld_cksum)
  );

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h, expected %08h", tag, act, exp);
    end
  endtask

  task automatic check_cksum(input logic [31:0] exp_en);
`ifdef IMEM_CKSUM_EN
    check("ld_cksum", ld_cksum, exp_en);
`else
    check("ld_cksum_tied", ld_cksum, 32'h0);
    if (exp_en == 32'hFFFF_FFFF) $display("unreachable checksum value");
`endif
  endtask

  task automatic start_load();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_end);
    bus.ld_valid = 1'b1;
    bus.ld_byte  = b;
    bus.ld_end   = with_end;
    check("ld_ready", 32'(bus.ld_ready), 32'd1);
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_end   = 1'b0;
  endtask

  task automatic end_load();
    bus.ld_end = 1'b1;
    tick();
    bus.ld_end = 1'b0;
  endtask

  task automatic expect_word(input int unsigned idx, input logic [31:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Read each expected word back, once directly and once through the alias
  // one RAM-depth higher; low address bits are randomised.
  task automatic drain_fetch();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.ce   = 1'b1;
      bus.addr = ADDR_W'(e.idx * 4 + $urandom_range(0, 3));
      #1;
      check("fetch", bus.inst, e.data);
      bus.addr = ADDR_W'((e.idx + DEPTH) * 4);
      #1;
      check("fetch_alias", bus.inst, e.data);
    end
    bus.ce = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    logic [7:0] img1 [8];
    img1 = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};

    rst          = 1'b1;
    bus.ce       = 1'b0;
    bus.addr     = '0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_byte  = 8'h00;
    bus.ld_end   = 1'b0;
    #2 rst = 1'b0;
    #1;

    // Reset state
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_ld_words", 32'(ld_words), 32'd0);
    check("rst_ld_err", 32'(ld_err), 32'd0);
    check("rst_ld_cksum", ld_cksum, 32'h0);
    check("rst_inst_ce0", bus.inst, 32'h0);
    repeat (2) tick();
    check("rst_hold_held", 32'(core_hold), 32'd1);
    rst = 1'b1;
    tick();
    check("hold_after_reset", 32'(core_hold), 32'd0);

    // Basic two-word load
    start_load();
    check("load_core_hold", 32'(core_hold), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(img1[i], 1'b0);
    end_load();
    check("basic_ld_words", 32'(ld_words), 32'd2);
    check("basic_hold_idle1", 32'(core_hold), 32'd1);
    check("basic_ready_idle", 32'(bus.ld_ready), 32'd0);
    tick();
    check("basic_hold_release", 32'(core_hold), 32'd0);
    bus.ce   = 1'b1;
    bus.addr = 12'h004;
    #1;
    check("basic_fetch_004", bus.inst, 32'h00200093);
    bus.ce = 1'b0;
    #1;
    check("fetch_ce0", bus.inst, 32'h0);
    expect_word(0, 32'h00100013);
    expect_word(1, 32'h00200093);
    drain_fetch();
    check_cksum(32'h003000A6);

    // Partial word padded by FLUSH
    start_load();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    end_load();
    check("flush_ready", 32'(bus.ld_ready), 32'd0);
    check("flush_hold", 32'(core_hold), 32'd1);
    tick();
    check("partial_ld_words", 32'(ld_words), 32'd1);
    expect_word(0, 32'h00CCBBAA);
    expect_word(1, 32'h00200093);
    drain_fetch();
    check_cksum(32'h00CCBBAA);

    // ld_end on the same cycle as an accepted byte
    start_load();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b1);
    tick();
    check("end_with_byte_words", 32'(ld_words), 32'd2);
    expect_word(0, 32'h44332211);
    expect_word(1, 32'h00000055);
    drain_fetch();
    check_cksum(32'h44332266);

    // Overflow: 20 bytes into a 4-word RAM
    start_load();
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1), 1'b0);
    check("ovf_ld_err_set", 32'(ld_err), 32'd1);
    end_load();
    check("ovf_ld_words", 32'(ld_words), 32'd4);
    check("ovf_ld_err", 32'(ld_err), 32'd1);
    expect_word(0, 32'h04030201);
    expect_word(1, 32'h08070605);
    expect_word(2, 32'h0C0B0A09);
    expect_word(3, 32'h100F0E0D);
    drain_fetch();
    check_cksum(32'h2824201C);

    // Restart mid-load; byte offered with ld_start is dropped
    start_load();
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 1'b0);
    check("restart_pre_words", 32'(ld_words), 32'd1);
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'hFF;
    tick();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    check("restart_words", 32'(ld_words), 32'd0);
    check("restart_err_clr", 32'(ld_err), 32'd0);
    check_cksum(32'h0);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hB0 + i), 1'b0);
    end_load();
    check("restart_ld_words", 32'(ld_words), 32'd1);
    expect_word(0, 32'hB3B2B1B0);
    expect_word(1, 32'h08070605);
    drain_fetch();
    check_cksum(32'hB3B2B1B0);

    // Asynchronous reset in the middle of a load
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b0);
    check("arst_pre_words", 32'(ld_words), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_core_hold", 32'(core_hold), 32'd1);
    check("arst_ready_idle", 32'(bus.ld_ready), 32'd0);
    check("arst_ld_words", 32'(ld_words), 32'd0);
    bus.ce = 1'b0;
    #1;
    check("arst_inst_ce0", bus.inst, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check("arst_hold_release", 32'(core_hold), 32'd0);
    expect_word(0, 32'hC3C2C1C0);
    expect_word(1, 32'h08070605);
    drain_fetch();

    // Fetch of a word on the cycle it is written returns the old contents
    start_load();
    send_byte(8'hEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hDE, 1'b0);
    end_load();
    tick();
    start_load();
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    bus.ce       = 1'b1;
    bus.addr     = '0;
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'h12;
    #1;
    check("rw_same_cycle_old", bus.inst, 32'hDEADBEEF);
    tick();
    bus.ld_valid = 1'b0;
    check("rw_next_cycle_new", bus.inst, 32'h12345678);
    bus.ce = 1'b0;
    end_load();
    check("rw_ld_words", 32'(ld_words), 32'd1);
    check_cksum(32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
